// File: rtl/junction_pkg.sv
// Shared types and helpers for the junction arbiter: FSM state encoding and
// the channel-index width function.
package junction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Width of a channel index; never below one bit.
  function automatic int cw_of(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/junction_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first requesting
// index at or above ptr, wrapping around, plus an any-request flag.
module rr_pick
  import junction_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = cw_of(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from farthest to nearest so the closest request at/after ptr wins.
  always_comb begin : pick_proc
    int cand;
    idx  = '0;
    any  = |req;
    cand = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      if (req[cand]) begin
        idx = W'(cand);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/junction_arbiter.sv
// Packet-granular round-robin merge of CHANNELS byte streams into one
// registered AXI-Stream output, optionally prefixing each packet with a tag.
module junction_arbiter
  import junction_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int DW       = 8,
  parameter  int TAG_EN   = 1,
  localparam int CW       = cw_of(CHANNELS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [CHANNELS*DW-1:0] i_tdata,
  input  logic [CHANNELS-1:0]    i_tlast,
  input  logic [CHANNELS-1:0]    i_tvalid,
  output logic [CHANNELS-1:0]    o_tready,
  output logic [DW-1:0]          o_tdata,
  output logic                   o_tlast,
  output logic                   o_tvalid,
  input  logic                   i_tready,
  output logic [CW-1:0]          o_tid
);

  state_t          state_r;
  state_t          state_n_s;
  logic [CW-1:0]   grant_r;
  logic [CW-1:0]   grant_n_s;
  logic [CW-1:0]   rr_ptr_r;
  logic [CW-1:0]   rr_ptr_n_s;
  logic [CW-1:0]   pick_idx_s;
  logic            pick_any_s;
  logic            load_s;
  logic            hs_s;
  logic [DW-1:0]   sel_data_s;
  logic            sel_last_s;
  logic [DW-1:0]   tdata_n_s;
  logic            tlast_n_s;
  logic            tvalid_n_s;
  logic [CW-1:0]   tid_n_s;

  rr_pick #(
    .N (CHANNELS)
  ) u_rr_pick (
    .req (i_tvalid),
    .ptr (rr_ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign load_s     = !o_tvalid || i_tready;
  assign sel_data_s = i_tdata[grant_r*DW +: DW];
  assign sel_last_s = i_tlast[grant_r];
  assign hs_s       = i_tvalid[grant_r] && o_tready[grant_r];

  // Ready goes only to the granted channel, and only while the output can load.
  always_comb begin
    o_tready = '0;
    if (state_r == DATA) begin
      o_tready[grant_r] = load_s;
    end else begin
      o_tready = '0;
    end
  end

  // Next-state, grant/pointer and output-register next values.
  always_comb begin
    state_n_s  = state_r;
    grant_n_s  = grant_r;
    rr_ptr_n_s = rr_ptr_r;
    tdata_n_s  = o_tdata;
    tlast_n_s  = o_tlast;
    tid_n_s    = o_tid;
    tvalid_n_s = load_s ? 1'b0 : o_tvalid;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          grant_n_s = pick_idx_s;
          state_n_s = (TAG_EN != 0) ? TAG : DATA;
        end else begin
          state_n_s = IDLE;
        end
      end
      TAG: begin
        if (load_s) begin
          tdata_n_s  = DW'(grant_r);
          tlast_n_s  = 1'b0;
          tid_n_s    = grant_r;
          tvalid_n_s = 1'b1;
          state_n_s  = DATA;
        end else begin
          state_n_s = TAG;
        end
      end
      DATA: begin
        if (hs_s) begin
          tdata_n_s  = sel_data_s;
          tlast_n_s  = sel_last_s;
          tid_n_s    = grant_r;
          tvalid_n_s = 1'b1;
          if (sel_last_s) begin
            // Just-finished channel drops to lowest priority next round.
            rr_ptr_n_s = (grant_r == CW'(CHANNELS - 1)) ? '0 : grant_r + CW'(1);
            state_n_s  = IDLE;
          end else begin
            state_n_s = DATA;
          end
        end else begin
          state_n_s = DATA;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State, arbitration and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= IDLE;
      grant_r  <= '0;
      rr_ptr_r <= '0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_tvalid <= 1'b0;
      o_tid    <= '0;
    end else begin
      state_r  <= state_n_s;
      grant_r  <= grant_n_s;
      rr_ptr_r <= rr_ptr_n_s;
      o_tdata  <= tdata_n_s;
      o_tlast  <= tlast_n_s;
      o_tvalid <= tvalid_n_s;
      o_tid    <= tid_n_s;
    end
  end

endmodule

// File: tb/tb_junction_arbiter.sv
// Directed, table-checked bench for junction_arbiter: default 4-channel tagged
// instance plus a 2-channel untagged instance.
module tb_junction_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] tid;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_tdata;
  logic [3:0]  i_tlast, i_tvalid, o_tready;
  logic [7:0]  o_tdata;
  logic        o_tlast, o_tvalid, i_tready;
  logic [1:0]  o_tid;

  logic [15:0] i_tdata2;
  logic [1:0]  i_tlast2, i_tvalid2, o_tready2, hs2;
  logic [7:0]  o_tdata2;
  logic        o_tlast2, o_tvalid2, i_tready2;
  logic [0:0]  o_tid2;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [7:0]  src_data [4][32];
  logic        src_last [4][32];
  int          head [4];
  int          tail [4];
  beat_t       exp_q [$];
  beat_t       obs_q [$];
  logic        rand_ready, ready_val, prev_stall;
  beat_t       prev_beat;

  always #5 clk = ~clk;

  junction_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tid(o_tid)
  );

  junction_arbiter #(.CHANNELS(2), .DW(8), .TAG_EN(0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(i_tdata2), .i_tlast(i_tlast2),
    .i_tvalid(i_tvalid2), .o_tready(o_tready2), .o_tdata(o_tdata2),
    .o_tlast(o_tlast2), .o_tvalid(o_tvalid2), .i_tready(i_tready2), .o_tid(o_tid2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear();
    for (int c = 0; c < 4; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
    exp_q.delete();
    obs_q.delete();
    prev_stall = 1'b0;
    i_tvalid   = 4'b0;
    i_tlast    = 4'b0;
    i_tdata    = 32'b0;
  endtask

  task automatic push_beat(input int c, input logic [7:0] d, input logic l);
    src_data[c][tail[c]] = d;
    src_last[c][tail[c]] = l;
    tail[c]++;
  endtask

  task automatic add_pkt(input int c, input logic [7:0] first, input int len);
    for (int i = 0; i < len; i++) push_beat(c, first + 8'(i), (i == len - 1));
  endtask

  task automatic exp_pkt(input int c, input logic [7:0] first, input int len);
    exp_q.push_back('{8'(c), 1'b0, 2'(c)});
    for (int i = 0; i < len; i++) exp_q.push_back('{first + 8'(i), (i == len - 1), 2'(c)});
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int c = 0; c < 4; c++) if (head[c] < tail[c]) e = 1'b0;
    return e;
  endfunction

  // Drive at negedge, sample 1 ns later, well before the next posedge.
  task automatic cycle();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      if (head[c] < tail[c]) begin
        i_tvalid[c]       = 1'b1;
        i_tdata[c*8 +: 8] = src_data[c][head[c]];
        i_tlast[c]        = src_last[c][head[c]];
      end else begin
        i_tvalid[c]       = 1'b0;
        i_tdata[c*8 +: 8] = 8'h00;
        i_tlast[c]        = 1'b0;
      end
    end
    i_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    #1;
    chk("tready_onehot0", 32'($onehot0(o_tready)), 32'd1);
    if (prev_stall) begin
      chk("stall_valid", o_tvalid, 1);
      chk("stall_data", o_tdata, prev_beat.data);
      chk("stall_last", o_tlast, prev_beat.last);
      chk("stall_tid", o_tid, prev_beat.tid);
    end
    prev_stall = o_tvalid && !i_tready;
    prev_beat  = '{o_tdata, o_tlast, o_tid};
    for (int c = 0; c < 4; c++) if (i_tvalid[c] && o_tready[c]) head[c]++;
    if (o_tvalid && i_tready) obs_q.push_back('{o_tdata, o_tlast, o_tid});
  endtask

  task automatic compare(input string name);
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        chk($sformatf("%s_data[%0d]", name, i), obs_q[i].data, exp_q[i].data);
        chk($sformatf("%s_last[%0d]", name, i), obs_q[i].last, exp_q[i].last);
        chk($sformatf("%s_tid[%0d]", name, i), obs_q[i].tid, exp_q[i].tid);
      end
    end
  endtask

  task automatic drain(input string name, input int max_cycles);
    int idle = 0;
    for (int n = 0; n < max_cycles && idle < 3; n++) begin
      cycle();
      if (queues_empty() && !o_tvalid) idle++;
      else idle = 0;
    end
    chk({name, "_drained"}, (idle >= 3), 1);
    compare(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    i_tready   = 1'b0;
    i_tdata2   = 16'b0;
    i_tlast2   = 2'b0;
    i_tvalid2  = 2'b0;
    i_tready2  = 1'b0;
    hs2        = 2'b0;
    clear();
    #2;
    chk("reset_tvalid", o_tvalid, 0);
    chk("reset_tdata", o_tdata, 0);
    chk("reset_tlast", o_tlast, 0);
    chk("reset_tid", o_tid, 0);
    chk("reset_tready", o_tready, 0);
    chk("reset_tvalid2", o_tvalid2, 0);
    do_reset();

    // Single channel with tag.
    push_beat(2, 8'h11, 1'b0);
    push_beat(2, 8'h22, 1'b0);
    push_beat(2, 8'h33, 1'b1);
    exp_q.push_back('{8'h02, 1'b0, 2'd2});
    exp_q.push_back('{8'h11, 1'b0, 2'd2});
    exp_q.push_back('{8'h22, 1'b0, 2'd2});
    exp_q.push_back('{8'h33, 1'b1, 2'd2});
    drain("single", 40);

    // Contention: two rounds over all channels.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) add_pkt(c, 8'(c * 16 + r * 2), 2);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) exp_pkt(c, 8'(c * 16 + r * 2), 2);
    drain("contention", 100);

    // Fairness: ch3 served right after ch0's first packet.
    do_reset();
    add_pkt(0, 8'hA0, 2);
    add_pkt(0, 8'hB0, 1);
    add_pkt(0, 8'hC0, 2);
    add_pkt(3, 8'hD0, 3);
    exp_pkt(0, 8'hA0, 2);
    exp_pkt(3, 8'hD0, 3);
    exp_pkt(0, 8'hB0, 1);
    exp_pkt(0, 8'hC0, 2);
    drain("fairness", 100);

    // Random backpressure.
    do_reset();
    rand_ready = 1'b1;
    add_pkt(1, 8'h31, 3);
    add_pkt(2, 8'h41, 2);
    add_pkt(1, 8'h55, 1);
    exp_pkt(1, 8'h31, 3);
    exp_pkt(2, 8'h41, 2);
    exp_pkt(1, 8'h55, 1);
    drain("backpressure", 400);
    rand_ready = 1'b0;

    // Asynchronous reset on a stalled mid-packet output.
    do_reset();
    add_pkt(0, 8'h60, 3);
    ready_val = 1'b1;
    repeat (3) cycle();
    ready_val = 1'b0;
    repeat (2) cycle();
    chk("midpkt_tvalid", o_tvalid, 1);
    chk("midpkt_tdata", o_tdata, 8'h60);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", o_tvalid, 0);
    chk("async_rst_tdata", o_tdata, 0);
    chk("async_rst_tlast", o_tlast, 0);
    chk("async_rst_tid", o_tid, 0);
    chk("async_rst_tready", o_tready, 0);
    clear();
    ready_val = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    add_pkt(1, 8'h77, 1);
    exp_pkt(1, 8'h77, 1);
    drain("after_reset", 40);

    // Untagged two-channel instance: simultaneous single-beat packets.
    clear();
    exp_q.push_back('{8'hA5, 1'b1, 2'd0});
    exp_q.push_back('{8'h5A, 1'b1, 2'd1});
    i_tdata2  = {8'h5A, 8'hA5};
    i_tlast2  = 2'b11;
    i_tready2 = 1'b1;
    i_tvalid2 = 2'b11;
    hs2       = 2'b00;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      i_tvalid2 = i_tvalid2 & ~hs2;
      #1;
      chk("tready2_onehot0", 32'($onehot0(o_tready2)), 32'd1);
      hs2 = i_tvalid2 & o_tready2;
      if (o_tvalid2 && i_tready2) obs_q.push_back('{o_tdata2, o_tlast2, {1'b0, o_tid2}});
    end
    compare("tag_off");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
